mod_ctrl: RTL and testbench

//  Sequencer driving the iterative-subtraction modulo datapath (mod_dp) in the MIPS ALU.
//  - Accepts operands from the EX stage via start/busy/done handshake.
//  - Drives the datapath's operand, select and write-enable lines.
//  - Consumes is_less and result to return remainder, optional quotient and error flags.

---
 rtl/mod_ctrl_if.sv | 30 +++
 rtl/mod_ctrl.sv | 124 ++++++++++++
 tb/tb_mod_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_ctrl_if.sv
// Handshake and datapath bundle between the EX stage, the mod_ctrl sequencer and mod_dp.
// start is sampled only while busy=0; done (with err) pulses once per accepted request.
interface mod_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] rem_out;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_s;
    logic             dp_we;
    logic             dp_is_less;
    logic [WIDTH-1:0] dp_result;

    // master: EX stage plus the mod_dp feedback lines; slave: the sequencer.
    modport master (
        output start, a_in, b_in, dp_is_less, dp_result,
        input  busy, done, err, rem_out, quo_out, dp_a, dp_b, dp_s, dp_we
    );
    modport slave (
        input  start, a_in, b_in, dp_is_less, dp_result,
        output busy, done, err, rem_out, quo_out, dp_a, dp_b, dp_s, dp_we
    );
endinterface

// File: rtl/mod_ctrl.sv
// Sequencer for the iterative-subtraction modulo datapath (mod_dp).
// Define MOD_CTRL_QUOTIENT_EN to build the quotient counter; otherwise quo_out is 0.
module mod_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mod_ctrl_if.slave  bus,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_LOOP  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CNT_W-1:0] iter;

    logic iter_max;
    logic accept;
    logic first_go;
    logic first_fin;
    logic loop_fin;
    logic loop_step;

    assign iter_max  = (iter == CNT_W'(MAX_ITER));
    assign accept    = (state == S_IDLE) && bus.start;
    assign first_go  = (state == S_FIRST) && !bus.dp_is_less;
    assign first_fin = (state == S_FIRST) && bus.dp_is_less;
    assign loop_fin  = (state == S_LOOP) && bus.dp_is_less;
    // Timeout takes priority over a further write once the limit is reached.
    assign loop_step = (state == S_LOOP) && !bus.dp_is_less && !iter_max;

    assign bus.dp_a    = a_reg;
    assign bus.dp_b    = b_reg;
    assign bus.dp_s    = (state == S_LOOP);
    assign bus.dp_we   = first_go || loop_step;
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE) || (state == S_ERR);
    assign bus.err     = (state == S_ERR);
    assign bus.rem_out = rem_reg;
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            rem_reg <= '0;
            iter    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_reg <= bus.a_in;
                        b_reg <= bus.b_in;
                        iter  <= '0;
                        state <= (bus.b_in == '0) ? S_ERR : S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (first_fin) begin
                        rem_reg <= a_reg;
                        state   <= S_DONE;
                    end else begin
                        iter  <= CNT_W'(1);
                        state <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    if (loop_fin) begin
                        rem_reg <= bus.dp_result;
                        state   <= S_DONE;
                    end else if (iter_max) begin
                        state <= S_ERR;
                    end else begin
                        iter <= iter + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MOD_CTRL_QUOTIENT_EN
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] quo_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            quo_reg <= '0;
        end else begin
            if (accept) begin
                q <= '0;
            end else if (first_go) begin
                q <= WIDTH'(1);
            end else if (loop_step && (q != '1)) begin
                q <= q + WIDTH'(1);
            end
            if (first_fin) begin
                quo_reg <= '0;
            end else if (loop_fin) begin
                quo_reg <= q;
            end
        end
    end

    assign bus.quo_out = quo_reg;
`else
    assign bus.quo_out = '0;
`endif

endmodule

// File: tb/tb_mod_ctrl.sv
// Directed bench for mod_ctrl: behavioural mod_dp model, vector table, and
// hand-written sequences for re-start, held start and mid-operation reset.
module tb_mod_ctrl;
    localparam int W = 32;
`ifdef MOD_CTRL_QUOTIENT_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] state_dbg;
    logic [W-1:0] temp;

    int tests;
    int fails;

    mod_ctrl_if #(.WIDTH(W)) bus ();

    mod_ctrl #(.WIDTH(W), .MAX_ITER(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mod_dp model: temp <= selected - b on we; signed compare of selected vs b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) temp <= '0;
        else if (bus.dp_we) temp <= (bus.dp_s ? temp : bus.dp_a) - bus.dp_b;
    end
    assign bus.dp_is_less = $signed(bus.dp_s ? temp : bus.dp_a) < $signed(bus.dp_b);
    assign bus.dp_result  = temp;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Single start pulse; observe from the cycle after accept until done or budget.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int we_cnt, output logic e,
                          output logic [W-1:0] r, output logic [W-1:0] q,
                          output logic bz, output logic [W-1:0] da);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1; we_cnt = 0; e = 1'b0; r = '0; q = '0; bz = 1'b0; da = '0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.dp_we) we_cnt++;
            if (bus.done) begin
                lat = k; e = bus.err; r = bus.rem_out; q = bus.quo_out;
                bz = bus.busy; da = bus.dp_a;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] rem;
        logic [W-1:0] quo;
        logic         err;
        int           lat;
        int           we;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat, we_cnt, dcnt, first_d, second_d;
        logic e, bz;
        logic [W-1:0] r, q, da, r5;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;

        // Expected values with MAX_ITER = 4; error rows keep the previous rem/quo.
        vecs[0]  = '{32'd17,         32'd5,          32'd2,          32'd3, 1'b0, 5, 3};
        vecs[1]  = '{32'd9,          32'd0,          32'd2,          32'd3, 1'b1, 1, 0};
        vecs[2]  = '{32'd3,          32'd8,          32'd3,          32'd0, 1'b0, 2, 0};
        vecs[3]  = '{32'd100,        32'd1,          32'd3,          32'd0, 1'b1, 6, 4};
        vecs[4]  = '{32'd4,          32'd1,          32'd0,          32'd4, 1'b0, 6, 4};
        vecs[5]  = '{32'hFFFF_FFF9,  32'd3,          32'hFFFF_FFF9,  32'd0, 1'b0, 2, 0};
        vecs[6]  = '{32'd10,         32'd10,         32'd0,          32'd1, 1'b0, 3, 1};
        vecs[7]  = '{32'd20,         32'd6,          32'd2,          32'd3, 1'b0, 5, 3};
        vecs[8]  = '{32'd5,          32'd1,          32'd2,          32'd3, 1'b1, 6, 4};
        vecs[9]  = '{32'd0,          32'd7,          32'd0,          32'd0, 1'b0, 2, 0};
        vecs[10] = '{32'd7,          32'hFFFF_FFFE,  32'd0,          32'd0, 1'b1, 6, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_err",   {31'd0, bus.err},   32'd0);
        check("rst_dp_s",  {31'd0, bus.dp_s},  32'd0);
        check("rst_dp_we", {31'd0, bus.dp_we}, 32'd0);
        check("rst_rem",   bus.rem_out,        32'd0);
        check("rst_quo",   bus.quo_out,        32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, we_cnt, e, r, q, bz, da);
            check($sformatf("v%0d_lat", i),  lat,            vecs[i].lat);
            check($sformatf("v%0d_we", i),   we_cnt,         vecs[i].we);
            check($sformatf("v%0d_err", i),  {31'd0, e},     {31'd0, vecs[i].err});
            check($sformatf("v%0d_rem", i),  r,              vecs[i].rem);
            check($sformatf("v%0d_quo", i),  q,              QEN ? vecs[i].quo : 32'd0);
            check($sformatf("v%0d_busy", i), {31'd0, bz},    32'd1);
            check($sformatf("v%0d_dp_a", i), da,             vecs[i].a);
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", i), {31'd0, bus.busy}, 32'd0);
            check($sformatf("v%0d_idle_done", i), {31'd0, bus.done}, 32'd0);
        end

        // Start re-pulsed while busy, and again in the done cycle: both ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 32'd17; bus.b_in = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 32'd1; bus.b_in = 32'd1;
        dcnt = 0; r5 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                dcnt++;
                r5 = bus.rem_out;
                da = bus.dp_a;
                bus.start = 1'b1;
            end
        end
        bus.start = 1'b0;
        check("repulse_dones", dcnt, 32'd1);
        check("repulse_rem",   r5,   32'd2);
        check("repulse_dp_a",  da,   32'd17);
        check("repulse_busy",  {31'd0, bus.busy}, 32'd0);

        // Start held high: re-accept in the IDLE cycle after done
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 32'd3; bus.b_in = 32'd8;
        first_d = -1; second_d = -1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (first_d < 0) first_d = k;
                else second_d = k;
            end
        end
        bus.start = 1'b0;
        check("hold_first_done",  first_d,  32'd2);
        check("hold_second_done", second_d, 32'd5);
        repeat (2) @(negedge clk);
        check("hold_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Reset asserted in LOOP
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 32'd17; bus.b_in = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("midrst_in_loop", {29'd0, state_dbg}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, bus.busy},  32'd0);
        check("midrst_done",  {31'd0, bus.done},  32'd0);
        check("midrst_dp_we", {31'd0, bus.dp_we}, 32'd0);
        check("midrst_dp_s",  {31'd0, bus.dp_s},  32'd0);
        check("midrst_rem",   bus.rem_out,        32'd0);
        check("midrst_quo",   bus.quo_out,        32'd0);
        check("midrst_dp_a",  bus.dp_a,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("midrst_no_done", dcnt, 32'd0);
        run_op(32'd10, 32'd10, lat, we_cnt, e, r, q, bz, da);
        check("fresh_lat", lat,         32'd3);
        check("fresh_we",  we_cnt,      32'd1);
        check("fresh_err", {31'd0, e},  32'd0);
        check("fresh_rem", r,           32'd0);
        check("fresh_quo", q,           QEN ? 32'd1 : 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
